// File: rtl/id_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// id_hazard_ctrl_if
//   Bundle of the ID-stage issue-control signals exchanged between the
//   pipeline datapath and the hazard/issue controller.
//
//   master : pipeline side  (drives decode, EX-resolve and WB info;
//                            receives the stall/flush/bubble controls)
//   slave  : controller side (id_hazard_ctrl)
//
//   Signals
//     id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
//     id_rd, id_writes, id_ctrl           decoded IF/ID instruction
//     ex_resolve, ex_taken                control-instruction resolution in EX
//     wb_valid, wb_rd                     register-file write in WB
//     issue, stall_pc, stall_if_id,
//     bubble_id_ex, flush_if_id           pipeline controls
//     busy_mask                           per-register in-flight write flags
//     err                                 sticky protocol error
// -----------------------------------------------------------------------------
interface id_hazard_ctrl_if #(
  parameter int NREG = 16,
  parameter int AW   = 4
);
  logic            id_valid;
  logic [AW-1:0]   id_rs;
  logic [AW-1:0]   id_rt;
  logic            id_rs_used;
  logic            id_rt_used;
  logic [AW-1:0]   id_rd;
  logic            id_writes;
  logic            id_ctrl;
  logic            ex_resolve;
  logic            ex_taken;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;

  logic            issue;
  logic            stall_pc;
  logic            stall_if_id;
  logic            bubble_id_ex;
  logic            flush_if_id;
  logic [NREG-1:0] busy_mask;
  logic            err;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_writes,
           id_ctrl, ex_resolve, ex_taken, wb_valid, wb_rd,
    input  issue, stall_pc, stall_if_id, bubble_id_ex, flush_if_id,
           busy_mask, err
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_writes,
           id_ctrl, ex_resolve, ex_taken, wb_valid, wb_rd,
    output issue, stall_pc, stall_if_id, bubble_id_ex, flush_if_id,
           busy_mask, err
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// id_hazard_ctrl
//   ID-stage issue controller. Each cycle decides whether the instruction in
//   IF/ID advances into ID/EX or the front end stalls and a NOP bubble is
//   injected. A per-register scoreboard counts in-flight writes (RAW
//   interlock, no forwarding). Branch/call/ret are serialised: fetch is held
//   until EX resolves the control instruction; a taken redirect flushes IF/ID.
//
// Ports
//   clk  : clock
//   rst  : asynchronous reset, active-high
//   bus  : id_hazard_ctrl_if.slave (decode inputs, EX resolve, WB write,
//          issue/stall/bubble/flush controls, busy_mask, err)
//
// Configuration
//   IDHZ_WB_BYPASS_EN : register file is write-first, so a consumer may issue
//                       in the same cycle as its producer's last WB write.
//
// MAX_INFLIGHT must not exceed 2**CNT_W-1.
// -----------------------------------------------------------------------------
module id_hazard_ctrl #(
  parameter int NREG         = 16,
  parameter int AW           = 4,
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic             clk,
  input  logic             rst,
  id_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    CTRL_WAIT = 2'd1,
    FLUSH     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state;
  logic [CNT_W-1:0] cnt [NREG];
  logic             err_q;

  logic hz_rs, hz_rt, ovf, byp_rs, byp_rt, issue_c;

  // ---------------------------------------------------------------------------
  // Write-back bypass: a source whose only outstanding write retires this
  // cycle is readable now when the register file is write-first.
  // ---------------------------------------------------------------------------
`ifdef IDHZ_WB_BYPASS_EN
  assign byp_rs = bus.wb_valid && (bus.wb_rd == bus.id_rs) && (cnt[bus.id_rs] == CNT_ONE);
  assign byp_rt = bus.wb_valid && (bus.wb_rd == bus.id_rt) && (cnt[bus.id_rt] == CNT_ONE);
`else
  assign byp_rs = 1'b0;
  assign byp_rt = 1'b0;
`endif

  assign hz_rs = bus.id_rs_used && (cnt[bus.id_rs] != CNT_ZERO) && !byp_rs;
  assign hz_rt = bus.id_rt_used && (cnt[bus.id_rt] != CNT_ZERO) && !byp_rt;
  // A further write to a register whose counter is at its ceiling would wrap.
  assign ovf   = bus.id_writes && (cnt[bus.id_rd] == CNT_MAX);

  // Issue is suppressed while rst is asserted so the reset-state outputs hold
  // regardless of what IF/ID presents.
  assign issue_c = !rst && (state == RUN) && bus.id_valid && !hz_rs && !hz_rt && !ovf;

  // ---------------------------------------------------------------------------
  // Pipeline controls
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    bus.issue        = issue_c;
    bus.stall_pc     = 1'b0;
    bus.stall_if_id  = 1'b0;
    bus.bubble_id_ex = 1'b1;
    bus.flush_if_id  = 1'b0;

    if (!rst) begin
      unique case (state)
        RUN: begin
          bus.stall_pc     = bus.id_valid && !issue_c;
          bus.stall_if_id  = bus.id_valid && !issue_c;
          bus.bubble_id_ex = !issue_c;
        end
        CTRL_WAIT: begin
          bus.stall_pc    = 1'b1;
          bus.stall_if_id = 1'b1;
        end
        FLUSH: begin
          bus.flush_if_id = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy_mask = '0;
    for (int i = 0; i < NREG; i++) begin
      bus.busy_mask[i] = (cnt[i] != CNT_ZERO);
    end
  end

  assign bus.err = err_q;

  // ---------------------------------------------------------------------------
  // Control-serialisation FSM and sticky error
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others, whatever the order of
  // statements within the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        RUN:       if (issue_c && bus.id_ctrl) state <= CTRL_WAIT;
        CTRL_WAIT: if (bus.ex_resolve)         state <= bus.ex_taken ? FLUSH : RUN;
        FLUSH:                                 state <= RUN;
        default:                               state <= RUN;
      endcase

      // Resolve with nothing outstanding, or a write-back that retires a
      // write never issued, means the surrounding pipeline lost track.
      if (bus.ex_resolve && (state != CTRL_WAIT))
        err_q <= 1'b1;
      if (bus.wb_valid && (cnt[bus.wb_rd] == CNT_ZERO))
        err_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: in-flight write count per architectural register
  // ---------------------------------------------------------------------------
  // NOTE: the counters are ordinary flops, not a RAM, and must start at zero or
  // the first consumer of every register would stall forever; hence the whole
  // array sits under the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        logic inc, dec;
        inc = issue_c && bus.id_writes && (bus.id_rd == AW'(i));
        dec = bus.wb_valid && (bus.wb_rd == AW'(i));
        // Simultaneous issue and retire on one register cancel out.
        if (inc && !dec)
          cnt[i] <= cnt[i] + CNT_ONE;
        else if (dec && !inc && (cnt[i] != CNT_ZERO))
          cnt[i] <= cnt[i] - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_id_hazard_ctrl
//   Directed bench for id_hazard_ctrl: reset values, RAW interlock, in-flight
//   overflow, taken / not-taken control serialisation, scoreboard underflow
//   and same-cycle inc/dec, and reset from CTRL_WAIT.
// -----------------------------------------------------------------------------
module tb_id_hazard_ctrl;

`ifdef IDHZ_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  id_hazard_ctrl_if #(.NREG(16), .AW(4)) bus ();

  id_hazard_ctrl #(.NREG(16), .AW(4), .CNT_W(2), .MAX_INFLIGHT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // issue, stall_pc, stall_if_id, bubble_id_ex, flush_if_id
  task automatic check_ctl(input string tag, input logic iss, input logic stl,
                           input logic bub, input logic fl);
    check({tag, ".issue"},  32'(bus.issue),        32'(iss));
    check({tag, ".stl_pc"}, 32'(bus.stall_pc),     32'(stl));
    check({tag, ".stl_if"}, 32'(bus.stall_if_id),  32'(stl));
    check({tag, ".bubble"}, 32'(bus.bubble_id_ex), 32'(bub));
    check({tag, ".flush"},  32'(bus.flush_if_id),  32'(fl));
  endtask

  task automatic drv_id(input logic v, input logic [3:0] rs, input logic rsu,
                        input logic [3:0] rt, input logic rtu, input logic [3:0] rd,
                        input logic wr, input logic ctl);
    bus.id_valid   = v;
    bus.id_rs      = rs;
    bus.id_rs_used = rsu;
    bus.id_rt      = rt;
    bus.id_rt_used = rtu;
    bus.id_rd      = rd;
    bus.id_writes  = wr;
    bus.id_ctrl    = ctl;
  endtask

  task automatic drv_wb(input logic v, input logic [3:0] rd);
    bus.wb_valid = v;
    bus.wb_rd    = rd;
  endtask

  task automatic drv_ex(input logic res, input logic tk);
    bus.ex_resolve = res;
    bus.ex_taken   = tk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drv_id(0, 0, 0, 0, 0, 0, 0, 0);
    drv_wb(0, 0);
    drv_ex(0, 0);

    // ---- reset values ----
    #12;
    check_ctl("rst", 0, 0, 1, 0);
    check("rst.busy", 32'(bus.busy_mask), 32'h0);
    check("rst.err",  32'(bus.err),       32'h0);
    tick();
    rst = 1'b0;
    settle();

    // ---- RAW interlock on R5 ----
    drv_id(1, 4'd1, 1, 4'd2, 1, 4'd5, 1, 0);           // ADD R5
    settle();
    check_ctl("add", 1, 0, 0, 0);
    tick();
    drv_id(1, 4'd5, 1, 4'd6, 1, 4'd6, 1, 0);           // SUB R6 <- R5
    settle();
    check("raw.busy", 32'(bus.busy_mask), 32'h0020);
    check_ctl("raw1", 0, 1, 1, 0);
    tick();
    settle();
    check_ctl("raw2", 0, 1, 1, 0);
    tick();
    drv_wb(1, 4'd5);                                    // producer's WB
    settle();
    check_ctl("raw_wb", BYP, !BYP, !BYP, 0);
    tick();
    drv_wb(0, 0);
    drv_id(!BYP, 4'd5, 1, 4'd6, 1, 4'd6, 1, 0);         // still held unless bypassed
    settle();
    check_ctl("raw_go", !BYP, 0, BYP, 0);
    tick();
    drv_id(1, 4'd6, 0, 4'd6, 0, 4'd0, 0, 0);            // names R6 but reads nothing
    settle();
    check("raw.busy6", 32'(bus.busy_mask), 32'h0040);
    check("unused_src.issue", 32'(bus.issue), 32'h1);
    drv_wb(1, 4'd6);
    tick();
    drv_id(0, 0, 0, 0, 0, 0, 0, 0);
    drv_wb(0, 0);
    settle();
    check("raw.drained", 32'(bus.busy_mask), 32'h0);
    check("raw.err",     32'(bus.err),       32'h0);

    // ---- in-flight ceiling on R2 ----
    for (int k = 0; k < 3; k++) begin
      drv_id(1, 0, 0, 0, 0, 4'd2, 1, 0);
      settle();
      check($sformatf("w2_%0d.issue", k), 32'(bus.issue), 32'h1);
      tick();
    end
    settle();
    check("ovf.busy", 32'(bus.busy_mask), 32'h0004);
    check_ctl("ovf", 0, 1, 1, 0);
    tick();
    drv_wb(1, 4'd2);
    settle();
    check_ctl("ovf_wb", 0, 1, 1, 0);
    tick();
    drv_wb(0, 0);
    settle();
    check_ctl("ovf_go", 1, 0, 0, 0);
    tick();
    drv_id(0, 0, 0, 0, 0, 0, 0, 0);
    drv_wb(1, 4'd2);
    tick();
    tick();
    tick();
    drv_wb(0, 0);
    settle();
    check("ovf.drained", 32'(bus.busy_mask), 32'h0);

    // ---- taken branch ----
    drv_id(1, 0, 0, 0, 0, 0, 0, 1);
    settle();
    check_ctl("br_issue", 1, 0, 0, 0);
    tick();
    drv_id(1, 4'd1, 1, 0, 0, 0, 0, 0);                  // fall-through in IF/ID
    settle();
    check_ctl("br_wait1", 0, 1, 1, 0);
    tick();
    drv_ex(1, 1);
    settle();
    check_ctl("br_wait2", 0, 1, 1, 0);
    tick();
    drv_ex(0, 0);
    settle();
    check_ctl("br_flush", 0, 0, 1, 1);
    tick();
    drv_id(1, 4'd3, 1, 0, 0, 0, 0, 0);                  // branch target
    settle();
    check_ctl("br_run", 1, 0, 0, 0);
    tick();

    // ---- not-taken branch ----
    drv_id(1, 0, 0, 0, 0, 0, 0, 1);
    settle();
    check_ctl("nt_issue", 1, 0, 0, 0);
    tick();
    drv_id(1, 4'd1, 1, 0, 0, 0, 0, 0);
    settle();
    check_ctl("nt_wait", 0, 1, 1, 0);
    tick();
    drv_ex(1, 0);
    settle();
    check_ctl("nt_resolve", 0, 1, 1, 0);
    tick();
    drv_ex(0, 0);
    settle();
    check_ctl("nt_run", 1, 0, 0, 0);
    tick();
    drv_id(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("nt.err", 32'(bus.err), 32'h0);

    // ---- underflow sets sticky err ----
    drv_wb(1, 4'd7);
    settle();
    check("uf.err_before", 32'(bus.err), 32'h0);
    tick();
    drv_wb(0, 0);
    settle();
    check("uf.err",  32'(bus.err),       32'h1);
    check("uf.busy", 32'(bus.busy_mask), 32'h0);
    tick();
    tick();
    settle();
    check("uf.sticky", 32'(bus.err), 32'h1);

    // ---- same-cycle inc/dec on R4 ----
    drv_id(1, 0, 0, 0, 0, 4'd4, 1, 0);
    settle();
    check("r4a.issue", 32'(bus.issue), 32'h1);
    tick();
    drv_wb(1, 4'd4);
    settle();
    check("r4b.issue", 32'(bus.issue),     32'h1);
    check("r4b.busy",  32'(bus.busy_mask), 32'h0010);
    tick();
    drv_id(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("r4c.busy", 32'(bus.busy_mask), 32'h0010);   // count held at 1
    tick();                                            // the remaining WB
    drv_wb(0, 0);
    settle();
    check("r4d.busy", 32'(bus.busy_mask), 32'h0);
    check("r4d.err",  32'(bus.err),       32'h1);

    // ---- reset while in CTRL_WAIT with cnt[3]=2 ----
    drv_id(1, 0, 0, 0, 0, 4'd3, 1, 0);
    tick();
    tick();
    drv_id(1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drv_id(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("cw.busy",  32'(bus.busy_mask), 32'h0008);
    check("cw.stall", 32'(bus.stall_pc),  32'h1);
    rst = 1'b1;
    #1;
    check_ctl("cw_rst", 0, 0, 1, 0);
    check("cw_rst.busy", 32'(bus.busy_mask), 32'h0);
    check("cw_rst.err",  32'(bus.err),       32'h0);
    tick();
    rst = 1'b0;
    settle();

    // ---- stray resolve in RUN ----
    drv_ex(1, 1);
    tick();
    drv_ex(0, 0);
    settle();
    check("stray.err", 32'(bus.err), 32'h1);
    check_ctl("stray", 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
